// File: rtl/seq_divider_8b_4b_if.sv
// Operand/result handshake bundle for the sequential divider.
// The master supplies operands and consumes results; the slave is the divider.
interface seq_divider_8b_4b_if #(
  parameter int DW = 8,
  parameter int VW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;
  logic          q_fits;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, q_fits
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, q_fits
  );
endinterface

// File: rtl/seq_divider_8b_4b.sv
// Restoring divider, one quotient bit per clock, ready/valid on both sides.
// Inverse of the 4b x 4b multiplier: DW-bit dividend over VW-bit divisor.
module seq_divider_8b_4b #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input logic               clk,
  input logic               rst_n,
  seq_divider_8b_4b_if.slave bus
);
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_reg, state_next;
  logic [DW-1:0] q_sh_reg, q_sh_next;
  logic [VW:0]   rem_reg, rem_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [VW-1:0] divisor_reg, divisor_next;
  logic [DW-1:0] quotient_reg, quotient_next;
  logic [VW-1:0] remainder_reg, remainder_next;
  logic          dbz_reg, dbz_next;
  logic          q_fits_reg, q_fits_next;

  // One restoring step: shift the next dividend bit into the partial remainder.
  logic [VW:0]   trial;
  logic          trial_ge;
  logic [VW:0]   step_rem;
  logic [DW-1:0] step_q;

  assign trial    = (rem_reg << 1) | {{VW{1'b0}}, q_sh_reg[DW-1]};
  assign trial_ge = (trial >= {1'b0, divisor_reg});
  assign step_rem = trial_ge ? (trial - {1'b0, divisor_reg}) : trial;
  assign step_q   = {q_sh_reg[DW-2:0], trial_ge};

  assign bus.in_ready    = (state_reg == IDLE);
  assign bus.out_valid   = (state_reg == DONE);
  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.div_by_zero = dbz_reg;
  assign bus.q_fits      = q_fits_reg;

  always_comb begin
    state_next     = state_reg;
    q_sh_next      = q_sh_reg;
    rem_next       = rem_reg;
    cnt_next       = cnt_reg;
    divisor_next   = divisor_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    dbz_next       = dbz_reg;
    q_fits_next    = q_fits_reg;

    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          q_sh_next    = bus.dividend;
          rem_next     = '0;
          cnt_next     = '0;
          divisor_next = bus.divisor;
          if (bus.divisor != '0) begin
            state_next = CALC;
          end else begin
            // Zero divisor skips the iteration and reports a saturated quotient.
            state_next     = DONE;
            quotient_next  = '1;
            remainder_next = bus.dividend[VW-1:0];
            dbz_next       = 1'b1;
            q_fits_next    = 1'b0;
          end
        end
      end
      CALC: begin
        q_sh_next = step_q;
        rem_next  = step_rem;
        cnt_next  = cnt_reg + 1'b1;
        if (cnt_reg == CW'(DW - 1)) begin
          state_next     = DONE;
          quotient_next  = step_q;
          remainder_next = step_rem[VW-1:0];
          dbz_next       = 1'b0;
          q_fits_next    = (step_q[DW-1:VW] == '0);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      q_sh_reg      <= '0;
      rem_reg       <= '0;
      cnt_reg       <= '0;
      divisor_reg   <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
      q_fits_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      q_sh_reg      <= q_sh_next;
      rem_reg       <= rem_next;
      cnt_reg       <= cnt_next;
      divisor_reg   <= divisor_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      dbz_reg       <= dbz_next;
      q_fits_reg    <= q_fits_next;
    end
  end
endmodule

// File: tb/tb_seq_divider_8b_4b.sv
// Directed and randomized checks of the sequential divider's results,
// latency, handshake, backpressure and reset behaviour.
module tb_seq_divider_8b_4b;
  localparam int DW = 8;
  localparam int VW = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  seq_divider_8b_4b_if #(.DW(DW), .VW(VW)) bus ();

  seq_divider_8b_4b #(.DW(DW), .VW(VW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    logic       qf;
  } vec_t;

  // Drives one operand pair, waits for the result, then consumes it.
  // lat counts cycles from in_valid being presented to out_valid seen.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                        output logic [7:0] q, output logic [3:0] r,
                        output logic dz, output logic qf,
                        output int lat, output logic tmo);
    int n;
    tmo = 1'b0; lat = 0; q = '0; r = '0; dz = 1'b0; qf = 1'b0;
    @(negedge clk);
    bus.dividend = a; bus.divisor = b; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      tmo = 1'b1;
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 4'($urandom);
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 40);
    if (!bus.out_valid) begin
      tmo = 1'b1;
      return;
    end
    q = bus.quotient; r = bus.remainder; dz = bus.div_by_zero; qf = bus.q_fits;
    $display("op %0d/%0d -> q=%0d r=%0d dz=%0b qf=%0b lat=%0d", a, b, q, r, dz, qf, lat);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero, bus.q_fits}
        !== {1'b1, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: rdy=%0b vld=%0b q=%0d r=%0d dz=%0b qf=%0b required rdy=1 vld=0 q=0 r=0 dz=0 qf=0",
               bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero, bus.q_fits);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    vec_t v[12];
    logic [7:0] q;
    logic [3:0] r;
    logic dz, qf, tmo;
    int lat;
    v = '{'{8'd143, 4'd13, 8'd11,  4'd0, 1'b0, 1'b1},
          '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 1'b0},
          '{8'd225, 4'd15, 8'd15,  4'd0, 1'b0, 1'b1},
          '{8'd7,   4'd9,  8'd0,   4'd7, 1'b0, 1'b1},
          '{8'd0,   4'd5,  8'd0,   4'd0, 1'b0, 1'b1},
          '{8'd200, 4'd0,  8'd255, 4'd8, 1'b1, 1'b0},
          '{8'd100, 4'd7,  8'd14,  4'd2, 1'b0, 1'b1},
          '{8'd250, 4'd3,  8'd83,  4'd1, 1'b0, 1'b0},
          '{8'd16,  4'd1,  8'd16,  4'd0, 1'b0, 1'b0},
          '{8'd15,  4'd1,  8'd15,  4'd0, 1'b0, 1'b1},
          '{8'd0,   4'd0,  8'd255, 4'd0, 1'b1, 1'b0},
          '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 1'b0}};
    foreach (v[i]) begin
      run_op(v[i].a, v[i].b, q, r, dz, qf, lat, tmo);
      checks++;
      if (tmo !== 1'b0) begin
        failures++;
        $display("FAIL basic_timeout %0d/%0d: no result within bound", v[i].a, v[i].b);
      end
      checks++;
      if ({q, r} !== {v[i].q, v[i].r}) begin
        failures++;
        $display("FAIL basic_qr %0d/%0d: got q=%0d r=%0d required q=%0d r=%0d",
                 v[i].a, v[i].b, q, r, v[i].q, v[i].r);
      end
      checks++;
      if ({dz, qf} !== {v[i].dz, v[i].qf}) begin
        failures++;
        $display("FAIL basic_flags %0d/%0d: got dz=%0b qf=%0b required dz=%0b qf=%0b",
                 v[i].a, v[i].b, dz, qf, v[i].dz, v[i].qf);
      end
      checks++;
      if (lat !== (v[i].dz ? 1 : DW + 1)) begin
        failures++;
        $display("FAIL basic_latency %0d/%0d: got %0d required %0d",
                 v[i].a, v[i].b, lat, v[i].dz ? 1 : DW + 1);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int n;
    @(negedge clk);
    bus.dividend = 8'd7; bus.divisor = 4'd9; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    bus.dividend = 8'd200; bus.divisor = 4'd0; bus.in_valid = 1'b1;
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
      failures++;
      $display("FAIL busy_ready: rdy=%0b vld=%0b required rdy=0 vld=0", bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ({bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero} !== {1'b1, 8'd0, 4'd7, 1'b0}) begin
      failures++;
      $display("FAIL busy_result: vld=%0b q=%0d r=%0d dz=%0b required vld=1 q=0 r=7 dz=0",
               bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    $display("op 7/9 (busy pulse 200/0) -> q=%0d r=%0d", bus.quotient, bus.remainder);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
        failures++;
        $display("FAIL busy_no_extra cycle %0d: vld=%0b rdy=%0b required vld=0 rdy=1",
                 i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    bus.dividend = 8'd143; bus.divisor = 4'd13; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 40);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.q_fits}
          !== {1'b1, 1'b0, 8'd11, 4'd0, 1'b1}) begin
        failures++;
        $display("FAIL backpressure_hold cycle %0d: vld=%0b rdy=%0b q=%0d r=%0d qf=%0b required vld=1 rdy=0 q=11 r=0 qf=1",
                 i, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.q_fits);
      end
    end
    $display("op 143/13 (held 5 cycles) -> q=%0d r=%0d", bus.quotient, bus.remainder);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.quotient} !== {1'b0, 1'b1, 8'd11}) begin
        failures++;
        $display("FAIL backpressure_release cycle %0d: vld=%0b rdy=%0b q=%0d required vld=0 rdy=1 q=11",
                 i, bus.out_valid, bus.in_ready, bus.quotient);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc_t[2];
    logic [7:0] res_q[2];
    int n_acc, n_res;
    n_acc = 0; n_res = 0;
    acc_t[0] = 0; acc_t[1] = 0; res_q[0] = '0; res_q[1] = '0;
    @(negedge clk);
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.dividend = 8'd60; bus.divisor = 4'd5;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.out_valid && n_res < 2) begin
        res_q[n_res] = bus.quotient;
        $display("op b2b #%0d -> q=%0d r=%0d", n_res, bus.quotient, bus.remainder);
        n_res++;
      end
      if (bus.in_ready && bus.in_valid && n_acc < 2) begin
        acc_t[n_acc] = i;
        n_acc++;
        @(posedge clk);
        #1;
        if (n_acc == 1) begin
          bus.dividend = 8'd143; bus.divisor = 4'd13;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if ({n_acc, n_res} !== {32'd2, 32'd2}) begin
      failures++;
      $display("FAIL b2b_counts: accepts=%0d results=%0d required 2 and 2", n_acc, n_res);
    end
    checks++;
    if (acc_t[1] - acc_t[0] !== DW + 2) begin
      failures++;
      $display("FAIL b2b_throughput: accept spacing %0d required %0d", acc_t[1] - acc_t[0], DW + 2);
    end
    checks++;
    if ({res_q[0], res_q[1]} !== {8'd12, 8'd11}) begin
      failures++;
      $display("FAIL b2b_results: q0=%0d q1=%0d required 12 and 11", res_q[0], res_q[1]);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    logic [7:0] q;
    logic [3:0] r;
    logic dz, qf, tmo;
    int lat;
    @(negedge clk);
    bus.dividend = 8'd100; bus.divisor = 4'd7; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.quotient} !== {1'b1, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL reset_mid_async: rdy=%0b vld=%0b q=%0d required rdy=1 vld=0 q=0",
               bus.in_ready, bus.out_valid, bus.quotient);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_no_result: out_valid seen=%0b required 0", seen);
    end
    run_op(8'd100, 4'd7, q, r, dz, qf, lat, tmo);
    checks++;
    if ({tmo, q, r, dz} !== {1'b0, 8'd14, 4'd2, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_rerun: tmo=%0b q=%0d r=%0d dz=%0b required tmo=0 q=14 r=2 dz=0",
               tmo, q, r, dz);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, q, eq;
    logic [3:0] b, r, er;
    logic dz, qf, edz, eqf, tmo;
    int lat;
    for (int i = 0; i < 2000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 4'($urandom_range(0, 15));
      if (b == 4'd0) begin
        eq = 8'hFF; er = a[3:0]; edz = 1'b1; eqf = 1'b0;
      end else begin
        eq = a / {4'd0, b}; er = 4'(a % {4'd0, b}); edz = 1'b0; eqf = (eq < 8'd16);
      end
      run_op(a, b, q, r, dz, qf, lat, tmo);
      checks++;
      if ({tmo, q, r, dz, qf} !== {1'b0, eq, er, edz, eqf}) begin
        failures++;
        $display("FAIL random %0d/%0d: tmo=%0b q=%0d r=%0d dz=%0b qf=%0b required q=%0d r=%0d dz=%0b qf=%0b",
                 a, b, tmo, q, r, dz, qf, eq, er, edz, eqf);
      end
      if (b != 4'd0) begin
        checks++;
        if ((12'(q) * 12'(b) + 12'(r) !== 12'(a)) || (r >= b)) begin
          failures++;
          $display("FAIL identity %0d/%0d: q=%0d r=%0d required q*b+r=%0d and r<b", a, b, q, r, a);
        end
      end
    end
    for (int x = 0; x < 16; x++) begin
      for (int y = 1; y < 16; y++) begin
        run_op(8'(x * y), 4'(y), q, r, dz, qf, lat, tmo);
        checks++;
        if ({tmo, q, r, qf} !== {1'b0, 8'(x), 4'd0, 1'b1}) begin
          failures++;
          $display("FAIL product_inverse %0d*%0d: tmo=%0b q=%0d r=%0d qf=%0b required q=%0d r=0 qf=1",
                   x, y, tmo, q, r, qf, x);
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_busy_ignore();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
